// File: rtl/ec_point_double_seq_if.sv
// Valid/ready bus of the point doubler: projective point in, doubled point out.
interface ec_point_double_seq_if #(
    parameter int unsigned M = 4
) ();
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] X1;
    logic [M-1:0] Y1;
    logic [M-1:0] Z1;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] X2;
    logic [M-1:0] Y2;
    logic [M-1:0] Z2;

    modport master (
        output in_valid, X1, Y1, Z1, out_ready,
        input  in_ready, out_valid, X2, Y2, Z2
    );

    modport slave (
        input  in_valid, X1, Y1, Z1, out_ready,
        output in_ready, out_valid, X2, Y2, Z2
    );
endinterface

// File: rtl/ec_point_double_seq.sv
// Sequential Lopez-Dahab point doubler over GF(2^M): one shared field multiplier
// driven by a ten-step micro-schedule, valid/ready on both sides.
module ec_point_double_seq #(
    parameter int unsigned    M       = 4,
    parameter logic [M:0]     POLY    = 5'b10011,
    parameter logic [M-1:0]   A_CONST = 4'h4,
    parameter logic [M-1:0]   B_CONST = 4'h1
) (
    input logic                  clk,
    input logic                  rst_n,
    ec_point_double_seq_if.slave bus
);

    if (POLY[M] != 1'b1 || POLY[0] != 1'b1) begin : g_poly_check
        $error("POLY must have bit M and bit 0 set");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q;
    logic [3:0]   step_q;
    logic [M-1:0] x1_q, y1_q, z1_q;
    logic [M-1:0] zs_q, xs_q, zq_q, xq_q, bz_q, ys_q, s_q, p_q;
    logic [M-1:0] x2_q, y2_q, z2_q;
    logic [M-1:0] mul_a, mul_b, mul_p;

    // Operand routing: each step feeds exactly one product through the multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (step_q)
            4'd0: begin mul_a = z1_q;    mul_b = z1_q; end
            4'd1: begin mul_a = x1_q;    mul_b = x1_q; end
            4'd2: begin mul_a = zs_q;    mul_b = xs_q; end
            4'd3: begin mul_a = zs_q;    mul_b = zs_q; end
            4'd4: begin mul_a = xs_q;    mul_b = xs_q; end
            4'd5: begin mul_a = B_CONST; mul_b = zq_q; end
            4'd6: begin mul_a = y1_q;    mul_b = y1_q; end
            4'd7: begin mul_a = A_CONST; mul_b = z2_q; end
            4'd8: begin mul_a = x2_q;    mul_b = s_q;  end
            4'd9: begin mul_a = bz_q;    mul_b = z2_q; end
            default: begin mul_a = '0;   mul_b = '0;   end
        endcase
    end

    // MSB-first shift-and-add with reduction by POLY on every shift.
    always_comb begin
        mul_p = '0;
        for (int i = M - 1; i >= 0; i--) begin
            mul_p = {mul_p[M-2:0], 1'b0} ^ (mul_p[M-1] ? POLY[M-1:0] : '0);
            if (mul_b[i]) mul_p = mul_p ^ mul_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            z1_q    <= '0;
            zs_q    <= '0;
            xs_q    <= '0;
            zq_q    <= '0;
            xq_q    <= '0;
            bz_q    <= '0;
            ys_q    <= '0;
            s_q     <= '0;
            p_q     <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            z2_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        x1_q <= bus.X1;
                        y1_q <= bus.Y1;
                        z1_q <= bus.Z1;
                        // Z1 == 0 is the point at infinity: it doubles to itself.
                        if (bus.Z1 == '0) begin
                            x2_q    <= bus.X1;
                            y2_q    <= bus.Y1;
                            z2_q    <= bus.Z1;
                            state_q <= S_DONE;
                        end else begin
                            step_q  <= '0;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    case (step_q)
                        4'd0: zs_q <= mul_p;
                        4'd1: xs_q <= mul_p;
                        4'd2: z2_q <= mul_p;
                        4'd3: zq_q <= mul_p;
                        4'd4: xq_q <= mul_p;
                        4'd5: begin
                            bz_q <= mul_p;
                            x2_q <= xq_q ^ mul_p;
                        end
                        4'd6: ys_q <= mul_p;
                        4'd7: s_q  <= mul_p ^ ys_q ^ bz_q;
                        4'd8: p_q  <= mul_p;
                        4'd9: y2_q <= p_q ^ mul_p;
                        default: ;
                    endcase
                    if (step_q == 4'd9) begin
                        state_q <= S_DONE;
                    end else begin
                        step_q <= step_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Gated with rst_n so the unit never advertises ready while held in reset.
    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.X2        = x2_q;
    assign bus.Y2        = y2_q;
    assign bus.Z2        = z2_q;

endmodule

// File: doc/ec_point_double_seq.md
# ec_point_double_seq

Sequential, parametrised López-Dahab projective point-doubling unit over GF(2^M) for the binary elliptic curve y² + xy = x³ + a·x² + b. It computes Z2 = X1²·Z1², X2 = X1⁴ + b·Z1⁴ and Y2 = b·Z1⁴·Z2 + X2·(a·Z2 + Y1² + b·Z1⁴). It sits in the scalar-multiplication datapath alongside the point-add unit. It replaces the fixed 4-bit, fully combinational doubler with a single shared field multiplier, an FSM micro-sequence and valid/ready handshakes.

## Interface
- M, 4: field width in bits; M ≥ 2.
- POLY, 5'b10011: (M+1)-bit reduction polynomial, x⁴+x+1 by default. POLY[M] and POLY[0] are both 1; elaboration fails otherwise.
- A_CONST, 4'h4: M-bit curve coefficient a.
- B_CONST, 4'h1: M-bit curve coefficient b.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input point X1/Y1/Z1 is valid.
- in_ready  out  1  unit can accept a point; equals 1 when the FSM is in IDLE.
- X1, Y1, Z1  in  M each  projective input point.
- out_valid  out  1  X2/Y2/Z2 hold the result.
- out_ready  in  1  consumer accepts the result.
- X2, Y2, Z2  out  M each  projective doubled point.

## Operation
- Arithmetic: addition is bitwise XOR. Multiplication is one combinational GF(2^M) shift-and-reduce multiplier modulo POLY, instantiated once. Squaring uses the same multiplier with both operands equal. All values are M bits; there is no overflow.
- FSM states:
  - IDLE: in_ready=1. On in_valid, X1/Y1/Z1 are captured. If the captured Z1 == 0, go to DONE with X2/Y2/Z2 = X1/Y1/Z1 (point at infinity bypass). Otherwise go to CALC with step counter = 0.
  - CALC: one multiply per cycle, result written at the edge. After step 9, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Micro-schedule, one line per step. Temporaries are internal M-bit registers.
  - 0: Zs = Z1·Z1
  - 1: Xs = X1·X1
  - 2: Z2 = Zs·Xs
  - 3: Zq = Zs·Zs
  - 4: Xq = Xs·Xs
  - 5: bZ = B·Zq, and X2 = Xq ⊕ (B·Zq) in the same edge
  - 6: Ys = Y1·Y1
  - 7: S = (A·Z2) ⊕ Ys ⊕ bZ
  - 8: P = X2·S
  - 9: Y2 = P ⊕ (bZ·Z2)
- Input operands are registered at acceptance. Changes on X1/Y1/Z1 after acceptance have no effect.
- in_valid is ignored outside IDLE.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, out_valid = 0, X2/Y2/Z2 = 0, all temporaries = 0. in_ready reads 1 only after rst_n deasserts; it is 0 while rst_n is low.
- Acceptance edge E0 is the first rising edge with in_valid & in_ready.
- Normal path: steps occupy edges E1..E10. out_valid is high from E10 onward. Latency is 10 cycles from acceptance.
- Bypass path (Z1 == 0): out_valid is high from E0 onward. Latency is 0 cycles after acceptance; the result is visible in the next cycle.
- DONE with out_ready=0: out_valid and X2/Y2/Z2 stay stable for an unbounded time.
- Handshake edge with out_valid & out_ready: out_valid falls and in_ready rises. A new point is accepted no earlier than the following edge. Throughput is 1 point per 12 cycles, or 1 per 2 cycles on the bypass path.
- X2/Y2/Z2 are undefined-but-stable during CALC. Consumers sample them only when out_valid=1.
- rst_n asserted mid-CALC or in DONE aborts immediately to the reset values. No partial result is ever flagged valid.

## Test plan
- M=4 defaults. Input (X1,Y1,Z1) = (1,1,1) → (X2,Y2,Z2) = (0,1,1). out_valid rises exactly 10 cycles after acceptance.
- Input (2,0,1) → output (2,0,4).
- Input (5,9,0) → output (5,9,0), out_valid high the cycle after acceptance.
- Hold out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, and in_valid pulses are ignored. Release → handshake completes, and the next point is accepted one cycle later.
- Assert rst_n low at step 5 of a calculation → outputs 0, out_valid 0. After release, input (1,1,1) → (0,1,1).
- Randomised run against the closed-form formula, including a second configuration M=8, POLY=9'h11B, A_CONST=8'h01, B_CONST=8'h53 → all results match, and back-to-back in_valid with random out_ready never drops or duplicates a point.
